// File: rtl/cnt_checker_if.sv
// cnt_checker_if: counter-sample inputs and checker result outputs for cnt_checker.
interface cnt_checker_if;
    logic              cnt_rst;
    logic              mode;
    logic signed [9:0] cnt_in;
    logic              clr;
    logic signed [10:0] step;
    logic              range_err;
    logic              forbid_err;
    logic              step_err;
    logic              seed_err;
    logic              err_sticky;
    logic [7:0]        err_count;
    logic signed [9:0] min_cnt;
    logic signed [9:0] max_cnt;
    modport master (
        output cnt_rst, mode, cnt_in, clr,
        input  step, range_err, forbid_err, step_err, seed_err, err_sticky, err_count, min_cnt, max_cnt
    );
    modport slave (
        input  cnt_rst, mode, cnt_in, clr,
        output step, range_err, forbid_err, step_err, seed_err, err_sticky, err_count, min_cnt, max_cnt
    );
endinterface

// File: rtl/cnt_checker.sv
// cnt_checker: registered range/forbid/step/seed checker for an up/down counter.
// Define CNT_CHECKER_MINMAX_EN to track running signed min/max of the count.
module cnt_checker #(
    parameter int LO_BOUND      = -263,
    parameter int HI_BOUND      = 269,
    parameter int FORBID_VAL    = -47,
    parameter int SEED_VAL      = 17,
    parameter int UP_DELTA      = 4,
    parameter int UP_SKIP_AT    = -51,
    parameter int UP_SKIP_DELTA = 8,
    parameter int DN_DELTA      = -10,
    parameter int DN_SKIP_AT    = -37,
    parameter int DN_SKIP_DELTA = -20
) (
    input logic          clk,
    input logic          rst_n,
    cnt_checker_if.slave bus
);
    typedef enum logic [1:0] {INIT, RUN, FAIL} state_t;
    localparam logic signed [10:0] LO   = 11'(LO_BOUND);
    localparam logic signed [10:0] HI   = 11'(HI_BOUND);
    localparam logic signed [10:0] FB   = 11'(FORBID_VAL);
    localparam logic signed [10:0] SEED = 11'(SEED_VAL);
    localparam logic signed [10:0] U_D  = 11'(UP_DELTA);
    localparam logic signed [10:0] U_AT = 11'(UP_SKIP_AT);
    localparam logic signed [10:0] U_SK = 11'(UP_SKIP_DELTA);
    localparam logic signed [10:0] D_D  = 11'(DN_DELTA);
    localparam logic signed [10:0] D_AT = 11'(DN_SKIP_AT);
    localparam logic signed [10:0] D_SK = 11'(DN_SKIP_DELTA);
    state_t             state, state_d;
    logic signed [9:0]  prev_cnt;
    logic               prev_mode, prev_rst;
    logic signed [10:0] cur, prv, diff, want, step_d;
    logic               range_d, forbid_d, step_err_d, seed_err_d, viol;
    logic [7:0]         count_d;
    always_comb begin
        cur        = {bus.cnt_in[9], bus.cnt_in};
        prv        = {prev_cnt[9], prev_cnt};
        diff       = cur - prv;
        want       = prev_mode ? (prv == U_AT ? U_SK : U_D) : (prv == D_AT ? D_SK : D_D);
        range_d    = !bus.clr && ((cur < LO) || (cur > HI));
        forbid_d   = !bus.clr && (cur == FB);
        // the sample right after a counter reset is checked against the seed instead of a step
        seed_err_d = !bus.clr && state != INIT && prev_rst && !bus.cnt_rst && cur != SEED;
        step_err_d = !bus.clr && state != INIT && !prev_rst && !bus.cnt_rst && diff != want;
        viol       = range_d | forbid_d | seed_err_d | step_err_d;
        step_d     = (bus.clr || state == INIT) ? '0 : diff;
        count_d    = bus.clr ? '0 : (viol && bus.err_count != 8'hff) ? bus.err_count + 8'd1 : bus.err_count;
        state_d    = bus.clr ? INIT : viol ? FAIL : state == INIT ? RUN : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT;
            prev_cnt       <= '0;
            prev_mode      <= 1'b0;
            prev_rst       <= 1'b0;
            bus.step       <= '0;
            bus.range_err  <= 1'b0;
            bus.forbid_err <= 1'b0;
            bus.step_err   <= 1'b0;
            bus.seed_err   <= 1'b0;
            bus.err_sticky <= 1'b0;
            bus.err_count  <= '0;
        end else begin
            state          <= state_d;
            prev_cnt       <= bus.cnt_in;
            prev_mode      <= bus.mode;
            prev_rst       <= bus.cnt_rst;
            bus.step       <= step_d;
            bus.range_err  <= range_d;
            bus.forbid_err <= forbid_d;
            bus.step_err   <= step_err_d;
            bus.seed_err   <= seed_err_d;
            bus.err_sticky <= state_d == FAIL;
            bus.err_count  <= count_d;
        end
    end
`ifdef CNT_CHECKER_MINMAX_EN
    logic signed [9:0] min_q, max_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= 10'h1ff;
            max_q <= 10'h200;
        end else if (bus.clr) begin
            min_q <= bus.cnt_in;
            max_q <= bus.cnt_in;
        end else begin
            min_q <= bus.cnt_in < min_q ? bus.cnt_in : min_q;
            max_q <= bus.cnt_in > max_q ? bus.cnt_in : max_q;
        end
    end
    assign bus.min_cnt = min_q;
    assign bus.max_cnt = max_q;
`else
    assign bus.min_cnt = '0;
    assign bus.max_cnt = '0;
`endif
endmodule

// File: tb/tb_cnt_checker.sv
// tb_cnt_checker: vector table, corner sequences and randomized run against a reference model.
module tb_cnt_checker;
    localparam int LO = -263, HI = 269, FBV = -47, SEED = 17;
    localparam int UD = 4, UAT = -51, USK = 8, DD = -10, DAT = -37, DSK = -20;
    typedef struct {
        int r, m, v, c;
        int rg, fb, st, se, sticky, stp, cnt;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0, checks = 0;
    int   m_have, m_fail, m_prev, m_pmode, m_prst, m_cnt, m_min, m_max;
    int   e_rg, e_fb, e_st, e_se, e_step;
    cnt_checker_if bus();
    cnt_checker #(.LO_BOUND(LO), .HI_BOUND(HI), .FORBID_VAL(FBV), .SEED_VAL(SEED),
                  .UP_DELTA(UD), .UP_SKIP_AT(UAT), .UP_SKIP_DELTA(USK),
                  .DN_DELTA(DD), .DN_SKIP_AT(DAT), .DN_SKIP_DELTA(DSK))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_fail = 0; m_prev = 0; m_pmode = 0; m_prst = 0; m_cnt = 0;
        m_min = 511; m_max = -512;
        e_rg = 0; e_fb = 0; e_st = 0; e_se = 0; e_step = 0;
    endtask

    task automatic model(input int r, input int m, input int v, input int c);
        int want, d;
        want = m_pmode ? (m_prev == UAT ? USK : UD) : (m_prev == DAT ? DSK : DD);
        d = v - m_prev;
        if (c) begin
            e_rg = 0; e_fb = 0; e_st = 0; e_se = 0; e_step = 0;
            m_have = 0; m_fail = 0; m_cnt = 0; m_min = v; m_max = v;
        end else begin
            e_rg = (v < LO || v > HI);
            e_fb = (v == FBV);
            e_se = m_have && m_prst && !r && v != SEED;
            e_st = m_have && !m_prst && !r && d != want;
            e_step = m_have ? d : 0;
            if (e_rg || e_fb || e_se || e_st) begin
                m_fail = 1;
                if (m_cnt < 255) m_cnt++;
            end
            m_have = 1;
            if (v < m_min) m_min = v;
            if (v > m_max) m_max = v;
        end
        m_prev = v; m_pmode = m; m_prst = r;
    endtask

    task automatic drive(input int r, input int m, input int v, input int c);
        bus.cnt_rst = r[0]; bus.mode = m[0]; bus.cnt_in = 10'(v); bus.clr = c[0];
        model(r, m, v, c);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_minmax(input string nm, input int emin, input int emax);
`ifdef CNT_CHECKER_MINMAX_EN
        chk({nm, " min_cnt"}, int'(bus.min_cnt), emin);
        chk({nm, " max_cnt"}, int'(bus.max_cnt), emax);
`else
        chk({nm, " min_cnt"}, int'(bus.min_cnt), emin * 0);
        chk({nm, " max_cnt"}, int'(bus.max_cnt), emax * 0);
`endif
    endtask

    task automatic chk_model(input string nm);
        chk({nm, " range_err"}, int'(bus.range_err), e_rg);
        chk({nm, " forbid_err"}, int'(bus.forbid_err), e_fb);
        chk({nm, " step_err"}, int'(bus.step_err), e_st);
        chk({nm, " seed_err"}, int'(bus.seed_err), e_se);
        chk({nm, " err_sticky"}, int'(bus.err_sticky), m_fail);
        chk({nm, " err_count"}, int'(bus.err_count), m_cnt);
        chk({nm, " step"}, int'(bus.step), e_step);
        chk_minmax(nm, m_min, m_max);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " flags"}, int'({bus.range_err, bus.forbid_err, bus.step_err, bus.seed_err, bus.err_sticky}), 0);
        chk({nm, " step"}, int'(bus.step), 0);
        chk({nm, " err_count"}, int'(bus.err_count), 0);
        chk_minmax(nm, 511, -512);
    endtask

    initial begin
        vec_t vt[$];
        int cv, pm, pr;
        bus.cnt_rst = 1'b0; bus.mode = 1'b0; bus.cnt_in = '0; bus.clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        //        r  m  v    c   rg fb st se sticky step  cnt
        vt.push_back('{1, 1, 0,    0, 0, 0, 0, 0, 0, 0,    0});
        vt.push_back('{0, 1, 17,   0, 0, 0, 0, 0, 0, 17,   0});
        vt.push_back('{0, 1, 21,   0, 0, 0, 0, 0, 0, 4,    0});
        vt.push_back('{0, 1, -59,  1, 0, 0, 0, 0, 0, 0,    0});
        vt.push_back('{0, 1, -55,  0, 0, 0, 0, 0, 0, 0,    0});
        vt.push_back('{0, 1, -51,  0, 0, 0, 0, 0, 0, 4,    0});
        vt.push_back('{0, 1, -43,  0, 0, 0, 0, 0, 0, 8,    0});
        vt.push_back('{0, 1, -39,  0, 0, 0, 0, 0, 0, 4,    0});
        vt.push_back('{0, 0, -37,  1, 0, 0, 0, 0, 0, 0,    0});
        vt.push_back('{0, 0, -47,  0, 0, 1, 0, 0, 1, 0,    1});
        vt.push_back('{0, 0, -57,  0, 0, 0, 0, 0, 1, -10,  1});
        vt.push_back('{0, 0, 270,  0, 1, 0, 1, 0, 1, 327,  2});
        vt.push_back('{1, 0, 270,  0, 1, 0, 0, 0, 1, 0,    3});
        vt.push_back('{0, 0, 5,    0, 0, 0, 0, 1, 1, -265, 4});
        vt.push_back('{0, 0, 270,  1, 0, 0, 0, 0, 0, 0,    0});
        vt.push_back('{0, 0, 0,    0, 0, 0, 0, 0, 0, 0,    0});
        foreach (vt[i]) begin
            drive(vt[i].r, vt[i].m, vt[i].v, vt[i].c);
            chk($sformatf("vec%0d flags", i),
                int'({bus.range_err, bus.forbid_err, bus.step_err, bus.seed_err}),
                (vt[i].rg << 3) | (vt[i].fb << 2) | (vt[i].st << 1) | vt[i].se);
            chk($sformatf("vec%0d err_sticky", i), int'(bus.err_sticky), vt[i].sticky);
            chk($sformatf("vec%0d step", i), int'(bus.step), vt[i].stp);
            chk($sformatf("vec%0d err_count", i), int'(bus.err_count), vt[i].cnt);
        end
        for (int i = 0; i < 300; i++) drive(0, 0, 270, 0);
        chk("saturate err_count", int'(bus.err_count), 255);
        chk("saturate range_err", int'(bus.range_err), 1);
        drive(0, 0, 10, 1);
        drive(0, 0, -200, 0);
        drive(0, 0, 150, 0);
        chk_minmax("minmax seq", -200, 150);
        chk_model("minmax model");
        #2 rst_n = 1'b0;
        #1 chk_reset("async reset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 1, 100, 0);
        chk_model("post reset first");
        chk("post reset step_err", int'(bus.step_err), 0);
        cv = 100; pm = 1; pr = 0;
        for (int i = 0; i < 400; i++) begin
            int p, v, r, c, m;
            p = int'($urandom_range(99));
            m = ($urandom_range(9) == 0) ? 1 - pm : pm;
            v = pr ? SEED : cv + (pm ? (cv == UAT ? USK : UD) : (cv == DAT ? DSK : DD));
            if (p < 10) v = int'($urandom_range(1023)) - 512;
            if (v > 511 || v < -512) v = int'($urandom_range(600)) - 300;
            r = (p >= 10 && p < 16) ? 1 : 0;
            c = (p >= 97) ? 1 : 0;
            drive(r, m, v, c);
            chk_model($sformatf("rand%0d", i));
            cv = v; pm = m; pr = r;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
